maquina_estados: RTL and testbench



---
 rtl/maquina_estados.sv | 222 ++++++++++++++++++++++
 tb/tb_maquina_estados.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/maquina_estados.sv
// maquina_estados: top-level four-floor elevator controller.
//   Latches cabin buttons and hall calls into a per-floor request memory,
//   serves them in SCAN order (keep going while work remains ahead),
//   times travel and door dwell in seconds, and drives a 4-digit
//   multiplexed seven-segment display.
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   piso1..piso4   cabin buttons, floors 1..4
//   S1,S2,S3       hall calls up at floors 1..3
//   B2,B3,B4       hall calls down at floors 2..4
//   DISPLAY[7:0]   segments {dp,g,f,e,d,c,b,a}, active-low
//   ANODES[3:0]    digit enables, active-low
//
// state          | meaning
// REPOSO         | idle, doors closed, waiting for a request
// MOVIENDO       | travelling one floor every TRAVEL_S seconds
// PUERTA_ABIERTA | stopped with doors open for DOOR_S seconds
module maquina_estados #(
  parameter int SEC_TICKS     = 50_000_000,
  parameter int TRAVEL_S      = 3,
  parameter int DOOR_S        = 5,
  parameter int REFRESH_TICKS = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piso1,
  input  logic       piso2,
  input  logic       piso3,
  input  logic       piso4,
  input  logic       S1,
  input  logic       B2,
  input  logic       S2,
  input  logic       B3,
  input  logic       S3,
  input  logic       B4,
  output logic [7:0] DISPLAY,
  output logic [3:0] ANODES
);

  typedef enum logic [1:0] {
    REPOSO         = 2'd0,
    MOVIENDO       = 2'd1,
    PUERTA_ABIERTA = 2'd2
  } state_t;

  localparam int TW = $clog2(SEC_TICKS + 1);
  localparam int RW = $clog2(REFRESH_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(SEC_TICKS - 1);
  localparam logic [RW-1:0] REF_LAST    = RW'(REFRESH_TICKS - 1);
  localparam logic [3:0]    TRAVEL_LAST = 4'(TRAVEL_S - 1);
  localparam logic [3:0]    DOOR_LAST   = 4'(DOOR_S - 1);

  state_t        r_state, w_state_n;
  logic [1:0]    r_piso, w_piso_n, w_new;
  logic [1:0]    r_accion, w_accion_n;
  logic          r_puertas, w_puertas_n;
  logic [3:0]    r_cnt_seg, w_cnt_n;
  logic [3:0]    r_mem, w_req, w_pend, w_clr;
  logic          r_dir, w_dir_n;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [RW-1:0] r_ref_cnt;
  logic          w_ref_tc;
  logic [1:0]    r_digit, w_digit_n;
  logic [7:0]    r_display, w_seg_n;
  logic [3:0]    r_anodes;

  function automatic logic f_above(input logic [3:0] m, input logic [1:0] p);
    f_above = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i > int'(p) && m[i]) f_above = 1'b1;
  endfunction

  function automatic logic f_below(input logic [3:0] m, input logic [1:0] p);
    f_below = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i < int'(p) && m[i]) f_below = 1'b1;
  endfunction

  function automatic logic [7:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: f_hex7 = 8'hC0;  4'h1: f_hex7 = 8'hF9;
      4'h2: f_hex7 = 8'hA4;  4'h3: f_hex7 = 8'hB0;
      4'h4: f_hex7 = 8'h99;  4'h5: f_hex7 = 8'h92;
      4'h6: f_hex7 = 8'h82;  4'h7: f_hex7 = 8'hF8;
      4'h8: f_hex7 = 8'h80;  4'h9: f_hex7 = 8'h90;
      4'hA: f_hex7 = 8'h88;  4'hB: f_hex7 = 8'h83;
      4'hC: f_hex7 = 8'hC6;  4'hD: f_hex7 = 8'hA1;
      4'hE: f_hex7 = 8'h86;  default: f_hex7 = 8'h8E;
    endcase
  endfunction

  assign w_tick   = (r_tick_cnt == TICK_LAST);
  assign w_ref_tc = (r_ref_cnt == REF_LAST);
  assign w_req    = {piso4 | B4, piso3 | B3 | S3, piso2 | B2 | S2, piso1 | S1};
  // Decisions look at requests arriving this cycle too, so a call at the
  // current floor opens the door without ever showing up in memory.
  assign w_pend   = r_mem | w_req;

  always_comb begin
    w_state_n   = r_state;
    w_piso_n    = r_piso;
    w_accion_n  = r_accion;
    w_puertas_n = r_puertas;
    w_dir_n     = r_dir;
    w_clr       = '0;
    w_new       = r_piso;
    w_cnt_n     = r_cnt_seg;
    if (w_tick && r_state != REPOSO) w_cnt_n = r_cnt_seg + 4'd1;

    case (r_state)
      REPOSO: begin
        w_accion_n  = 2'd0;
        w_puertas_n = 1'b0;
        w_cnt_n     = '0;
        if (w_pend[r_piso]) begin
          w_clr[r_piso] = 1'b1;
          w_puertas_n   = 1'b1;
          w_state_n     = PUERTA_ABIERTA;
        end else if (f_above(w_pend, r_piso) && (r_dir || !f_below(w_pend, r_piso))) begin
          w_dir_n    = 1'b1;
          w_accion_n = 2'd1;
          w_state_n  = MOVIENDO;
        end else if (f_below(w_pend, r_piso)) begin
          w_dir_n    = 1'b0;
          w_accion_n = 2'd2;
          w_state_n  = MOVIENDO;
        end
      end

      MOVIENDO: begin
        w_puertas_n = 1'b0;
        if (w_tick && r_cnt_seg == TRAVEL_LAST) begin
          w_cnt_n = '0;
          // Saturate at the shaft ends even if scheduling were ever wrong.
          if (r_dir && r_piso != 2'd3)       w_new = r_piso + 2'd1;
          else if (!r_dir && r_piso != 2'd0) w_new = r_piso - 2'd1;
          w_piso_n = w_new;
          if (w_pend[w_new]) begin
            w_clr[w_new] = 1'b1;
            w_accion_n   = 2'd0;
            w_puertas_n  = 1'b1;
            w_state_n    = PUERTA_ABIERTA;
          end else if (r_dir ? f_above(w_pend, w_new) : f_below(w_pend, w_new)) begin
            w_state_n = MOVIENDO;
          end else if (r_dir ? f_below(w_pend, w_new) : f_above(w_pend, w_new)) begin
            w_dir_n    = ~r_dir;
            w_accion_n = r_dir ? 2'd2 : 2'd1;
          end else begin
            w_accion_n = 2'd0;
            w_state_n  = REPOSO;
          end
        end
      end

      PUERTA_ABIERTA: begin
        w_accion_n    = 2'd0;
        w_puertas_n   = 1'b1;
        w_clr[r_piso] = 1'b1;
        if (w_req[r_piso]) begin
          w_cnt_n = '0;
        end else if (w_tick && r_cnt_seg == DOOR_LAST) begin
          w_cnt_n     = '0;
          w_puertas_n = 1'b0;
          w_state_n   = REPOSO;
        end
      end

      default: begin
        w_state_n = REPOSO;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    w_digit_n = w_ref_tc ? r_digit + 2'd1 : r_digit;
    w_seg_n   = 8'hFF;
    case (w_digit_n)
      2'd0: w_seg_n = f_hex7(r_cnt_seg);
      2'd1: w_seg_n = r_puertas ? 8'h88 : 8'hC6;
      2'd2: w_seg_n = (r_accion == 2'd1) ? 8'h92 :
                      (r_accion == 2'd2) ? 8'h83 : 8'hBF;
      default: w_seg_n = f_hex7({2'b00, r_piso} + 4'd1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REPOSO;
      r_piso     <= '0;
      r_accion   <= '0;
      r_puertas  <= 1'b0;
      r_cnt_seg  <= '0;
      r_mem      <= '0;
      r_dir      <= 1'b1;
      r_tick_cnt <= '0;
      r_ref_cnt  <= '0;
      r_digit    <= '0;
      r_anodes   <= 4'b1110;
      r_display  <= 8'hC0;
    end else begin
      r_state    <= w_state_n;
      r_piso     <= w_piso_n;
      r_accion   <= w_accion_n;
      r_puertas  <= w_puertas_n;
      r_cnt_seg  <= w_cnt_n;
      r_mem      <= (r_mem | w_req) & ~w_clr;
      r_dir      <= w_dir_n;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_ref_cnt  <= w_ref_tc ? '0 : r_ref_cnt + RW'(1);
      r_digit    <= w_digit_n;
      r_anodes   <= ~(4'b0001 << w_digit_n);
      r_display  <= w_seg_n;
    end
  end

  assign DISPLAY = r_display;
  assign ANODES  = r_anodes;

endmodule

// File: tb/tb_maquina_estados.sv
module tb_maquina_estados;

  localparam logic [31:0] ST_REPOSO  = 32'd0;
  localparam logic [31:0] ST_MOV     = 32'd1;
  localparam logic [31:0] ST_PUERTA  = 32'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       piso1 = 1'b0, piso2 = 1'b0, piso3 = 1'b0, piso4 = 1'b0;
  logic       S1 = 1'b0, B2 = 1'b0, S2 = 1'b0, B3 = 1'b0, S3 = 1'b0, B4 = 1'b0;
  logic [7:0] DISPLAY;
  logic [3:0] ANODES;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;

  logic [7:0] s_floor, s_act, s_door;

  always #5 clk = ~clk;

  maquina_estados #(
    .SEC_TICKS(4), .TRAVEL_S(3), .DOOR_S(5), .REFRESH_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .piso1(piso1), .piso2(piso2), .piso3(piso3), .piso4(piso4),
    .S1(S1), .B2(B2), .S2(S2), .B3(B3), .S3(S3), .B4(B4),
    .DISPLAY(DISPLAY), .ANODES(ANODES)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_edge++;
    end
  endtask

  task automatic step_to(input int t);
    while (n_edge < t) step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {piso1, piso2, piso3, piso4} = '0;
    {S1, B2, S2, B3, S3, B4} = '0;
    step(3);
    rst = 1'b0;
    n_edge = 0;
  endtask

  // Eight cycles cover every digit once at REFRESH_TICKS=2.
  task automatic scan(output logic [7:0] fl, output logic [7:0] ac, output logic [7:0] dr);
    fl = 8'hFF; ac = 8'hFF; dr = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step(1);
      case (ANODES)
        4'b0111: fl = DISPLAY;
        4'b1011: ac = DISPLAY;
        4'b1101: dr = DISPLAY;
        default: ;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and display rotation
    do_reset();
    chk("rst_piso",  32'(dut.r_piso), 0);
    chk("rst_state", 32'(dut.r_state), ST_REPOSO);
    chk("rst_mem",   32'(dut.r_mem), 0);
    chk("rst_dir",   32'(dut.r_dir), 1);
    chk("rst_an",    32'(ANODES), 32'hE);
    chk("rst_disp",  32'(DISPLAY), 32'hC0);
    step_to(1); chk("an_e1", 32'(ANODES), 32'hE); chk("d0_cnt", 32'(DISPLAY), 32'hC0);
    step_to(2); chk("an_e2", 32'(ANODES), 32'hD); chk("d1_door", 32'(DISPLAY), 32'hC6);
    step_to(4); chk("an_e4", 32'(ANODES), 32'hB); chk("d2_act", 32'(DISPLAY), 32'hBF);
    step_to(6); chk("an_e6", 32'(ANODES), 32'h7); chk("d3_floor", 32'(DISPLAY), 32'hF9);
    step_to(8); chk("an_e8", 32'(ANODES), 32'hE);

    // Single trip to floor 2
    do_reset();
    piso2 = 1'b1;
    step_to(1);
    chk("t2_state", 32'(dut.r_state), ST_MOV);
    chk("t2_accion", 32'(dut.r_accion), 1);
    chk("t2_mem", 32'(dut.r_mem), 32'b0010);
    step_to(5);
    piso2 = 1'b0;
    step_to(11);
    chk("t2_piso_pre", 32'(dut.r_piso), 0);
    chk("t2_cnt_pre", 32'(dut.r_cnt_seg), 2);
    step_to(12);
    chk("t2_piso", 32'(dut.r_piso), 1);
    chk("t2_puertas", 32'(dut.r_puertas), 1);
    chk("t2_mem_clr", 32'(dut.r_mem), 0);
    chk("t2_st_open", 32'(dut.r_state), ST_PUERTA);
    scan(s_floor, s_act, s_door);
    chk("t2_dsp_floor", 32'(s_floor), 32'hA4);
    chk("t2_dsp_act", 32'(s_act), 32'hBF);
    chk("t2_dsp_door", 32'(s_door), 32'h88);
    step_to(31);
    chk("t2_open_last", 32'(dut.r_puertas), 1);
    chk("t2_cnt_last", 32'(dut.r_cnt_seg), 4);
    step_to(32);
    chk("t2_closed", 32'(dut.r_puertas), 0);
    chk("t2_reposo", 32'(dut.r_state), ST_REPOSO);

    // Call at the current floor opens without moving
    do_reset();
    S1 = 1'b1;
    step_to(1);
    S1 = 1'b0;
    chk("t3_state", 32'(dut.r_state), ST_PUERTA);
    chk("t3_puertas", 32'(dut.r_puertas), 1);
    chk("t3_mem", 32'(dut.r_mem), 0);
    chk("t3_piso", 32'(dut.r_piso), 0);
    step_to(2);
    chk("t3_mem2", 32'(dut.r_mem), 0);
    chk("t3_accion", 32'(dut.r_accion), 0);

    // Up to 4 with an intermediate stop at 2, then a down call
    do_reset();
    piso4 = 1'b1;
    step_to(1);
    piso4 = 1'b0;
    B2 = 1'b1;
    step_to(2);
    B2 = 1'b0;
    chk("t4_mem", 32'(dut.r_mem), 32'b1010);
    scan(s_floor, s_act, s_door);
    chk("t4_dsp_floor", 32'(s_floor), 32'hF9);
    chk("t4_dsp_up", 32'(s_act), 32'h92);
    chk("t4_dsp_door", 32'(s_door), 32'hC6);
    step_to(12);
    chk("t4_stop2", 32'(dut.r_piso), 1);
    chk("t4_open2", 32'(dut.r_puertas), 1);
    chk("t4_mem2", 32'(dut.r_mem), 32'b1000);
    step_to(33);
    chk("t4_resume", 32'(dut.r_state), ST_MOV);
    chk("t4_resume_up", 32'(dut.r_accion), 1);
    step_to(44);
    chk("t4_pass3", 32'(dut.r_piso), 2);
    chk("t4_pass3_st", 32'(dut.r_state), ST_MOV);
    step_to(56);
    chk("t4_piso4", 32'(dut.r_piso), 3);
    chk("t4_open4", 32'(dut.r_puertas), 1);
    chk("t4_mem4", 32'(dut.r_mem), 0);
    step_to(57);
    S1 = 1'b1;
    step_to(58);
    S1 = 1'b0;
    chk("t4_mem_s1", 32'(dut.r_mem), 32'b0001);
    step_to(77);
    chk("t4_down", 32'(dut.r_accion), 2);
    chk("t4_dir", 32'(dut.r_dir), 0);
    scan(s_floor, s_act, s_door);
    chk("t4_dsp_floor4", 32'(s_floor), 32'h99);
    chk("t4_dsp_down", 32'(s_act), 32'h83);

    // Dwell extension at floor 3
    do_reset();
    piso3 = 1'b1;
    step_to(1);
    piso3 = 1'b0;
    step_to(24);
    chk("t5_piso", 32'(dut.r_piso), 2);
    chk("t5_open", 32'(dut.r_state), ST_PUERTA);
    step_to(32);
    chk("t5_cnt_mid", 32'(dut.r_cnt_seg), 2);
    step_to(33);
    piso3 = 1'b1;
    step_to(34);
    piso3 = 1'b0;
    chk("t5_cnt_rst", 32'(dut.r_cnt_seg), 0);
    chk("t5_mem", 32'(dut.r_mem), 0);
    step_to(51);
    chk("t5_still_open", 32'(dut.r_puertas), 1);
    step_to(52);
    chk("t5_closed", 32'(dut.r_puertas), 0);
    chk("t5_reposo", 32'(dut.r_state), ST_REPOSO);

    // Reset while travelling between floors 2 and 3
    do_reset();
    piso4 = 1'b1;
    step_to(1);
    piso4 = 1'b0;
    step_to(14);
    chk("t6_piso_pre", 32'(dut.r_piso), 1);
    rst = 1'b1;
    step(1);
    chk("t6_piso", 32'(dut.r_piso), 0);
    chk("t6_puertas", 32'(dut.r_puertas), 0);
    chk("t6_mem", 32'(dut.r_mem), 0);
    chk("t6_accion", 32'(dut.r_accion), 0);
    chk("t6_state", 32'(dut.r_state), ST_REPOSO);
    chk("t6_an", 32'(ANODES), 32'hE);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
